plic_init_sequencer: RTL and testbench

//  AXI4-Lite master that configures the PLIC after reset, before the core runs.

---
 rtl/plic_init_sequencer.sv | 117 +++++++++++
 tb/tb_plic_init_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_init_sequencer.sv
// plic_init_sequencer: AXI4-Lite master that writes the PLIC source priorities, context-0 enable and threshold after reset.
module plic_init_sequencer #(
    parameter int                                C_M00_AXI_DATA_WIDTH = 32,
    parameter int                                C_M00_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] BASE_ADDR            = 'h30_0000,
    parameter int                                NUM_SRC              = 2,
    parameter logic [C_M00_AXI_DATA_WIDTH-1:0] PRIORITY             = 1,
    parameter logic [C_M00_AXI_DATA_WIDTH-1:0] THRESHOLD            = 0,
    parameter int                                TIMEOUT              = 1024
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]                      m_axil_awprot,
    output logic                            m_axil_awvalid,
    input  logic                            m_axil_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [3:0]                      m_axil_wstrb,
    output logic                            m_axil_wvalid,
    input  logic                            m_axil_wready,
    input  logic [1:0]                      m_axil_bresp,
    input  logic                            m_axil_bvalid,
    output logic                            m_axil_bready
);
    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int IW = $clog2(NUM_SRC + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [IW-1:0] K_EN   = IW'(NUM_SRC);
    localparam logic [IW-1:0] K_LAST = IW'(NUM_SRC + 1);
    localparam logic [DW-1:0] EN_WORD = DW'((64'd1 << (NUM_SRC + 1)) - 64'd2);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_error;
    logic [AW-1:0] r_awaddr;
    logic [DW-1:0] r_wdata;
    logic [TW-1:0] r_tcnt;

    logic          w_start;
    logic          w_bdone;
    logic          w_adv;
    logic [IW-1:0] w_load_idx;
    logic [AW-1:0] w_load_addr;
    logic [DW-1:0] w_load_data;

    assign w_start    = (r_state == S_IDLE || r_state == S_DONE) && start_i;
    assign w_bdone    = r_state == S_RESP && m_axil_bvalid;
    assign w_adv      = w_bdone && r_idx != K_LAST;
    assign w_load_idx = w_start ? '0 : r_idx + 1'b1;
    // Source k's priority register sits at BASE + 4*(k+1); source 0 is reserved
    assign w_load_addr = w_load_idx == K_EN   ? BASE_ADDR + AW'(32'h2000) :
                         w_load_idx == K_LAST ? BASE_ADDR + AW'(32'h20_0000) :
                                                BASE_ADDR + AW'({w_load_idx, 2'b00}) + AW'(4);
    assign w_load_data = w_load_idx == K_EN   ? EN_WORD :
                         w_load_idx == K_LAST ? THRESHOLD : PRIORITY;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_error   <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_tcnt    <= '0;
        end else begin
            if (r_state == S_ADDR || r_state == S_RESP) begin
                if (r_tcnt != T_MAX) r_tcnt <= r_tcnt + 1'b1;
                if (r_tcnt == T_MAX - 1'b1) r_error <= 1'b1;
            end
            if (r_state == S_ADDR) begin
                if (m_axil_awready) r_awvalid <= 1'b0;
                if (m_axil_wready) r_wvalid <= 1'b0;
                if ((!r_awvalid || m_axil_awready) && (!r_wvalid || m_axil_wready)) r_state <= S_RESP;
            end
            if (w_bdone) begin
                if (m_axil_bresp != 2'b00) r_error <= 1'b1;
                if (!w_adv) r_state <= S_DONE;
            end
            // Errors never abort: the full write list is always issued
            if (w_start || w_adv) begin
                r_state   <= S_ADDR;
                r_idx     <= w_load_idx;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= w_load_addr;
                r_wdata   <= w_load_data;
                r_tcnt    <= '0;
                if (w_start) r_error <= 1'b0;
            end
        end
    end

    assign busy_o         = r_state == S_ADDR || r_state == S_RESP;
    assign done_o         = r_state == S_DONE;
    assign error_o        = r_error;
    assign m_axil_awaddr  = r_awaddr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_state == S_RESP;
endmodule

// File: tb/tb_plic_init_sequencer.sv
// tb_plic_init_sequencer: randomized AXI-Lite slave plus a write-list reference model for plic_init_sequencer.
module tb_plic_init_sequencer;
    localparam int NUM_SRC = 2;
    localparam int TIMEOUT = 1024;
    localparam int NW = NUM_SRC + 2;
    localparam logic [31:0] BASE = 32'h0030_0000;

    logic aclk = 1'b0, aresetn = 1'b1, start_i = 1'b0;
    logic busy_o, done_o, error_o;
    logic [31:0] awaddr, wdata;
    logic [2:0] awprot;
    logic [3:0] wstrb;
    logic awvalid, wvalid, bready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0] bresp = 2'b00;

    int tests_run = 0, fails = 0;
    int aw_delay = 0, w_delay = 0, b_delay = 0, err_idx = -1;
    bit b_stall = 1'b0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, pa = 0, pw = 0, b_tot = 0, viol = 0;
    int n_aw_first = 0, n_w_first = 0;
    bit prev_aw = 1'b0, prev_w = 1'b0;
    logic [31:0] prev_awaddr = '0, prev_wdata = '0;
    logic [31:0] aw_log[$], w_log[$];

    plic_init_sequencer #(.NUM_SRC(NUM_SRC), .TIMEOUT(TIMEOUT), .BASE_ADDR(BASE)) dut (
        .aclk(aclk), .aresetn(aresetn), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready)
    );

    always #5 aclk = ~aclk;

    // Slave and protocol monitor act on the falling edge; handshakes complete on the next rising edge
    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_wait = 0; w_wait = 0; b_wait = 0; pa = 0; pw = 0; prev_aw = 1'b0; prev_w = 1'b0;
        end else begin
            if (pa > 0 && pw > 0 && !b_stall && b_wait >= b_delay) bvalid = 1'b1;
            else begin
                bvalid = 1'b0;
                if (pa > 0 && pw > 0 && !b_stall) b_wait++;
            end
            bresp = (b_tot == err_idx) ? 2'b10 : 2'b00;
            if (bvalid && bready) begin b_tot++; pa--; pw--; b_wait = 0; end
            if (prev_aw && (awvalid !== 1'b1 || awaddr !== prev_awaddr)) viol++;
            if (prev_w && (wvalid !== 1'b1 || wdata !== prev_wdata)) viol++;
            awready = awvalid && aw_wait >= aw_delay;
            if (awready) begin aw_log.push_back(awaddr); pa++; aw_wait = 0; end
            else if (awvalid) aw_wait++;
            wready = wvalid && w_wait >= w_delay;
            if (wready) begin w_log.push_back(wdata); pw++; w_wait = 0; end
            else if (wvalid) w_wait++;
            prev_aw = awvalid && !awready; prev_awaddr = awaddr;
            prev_w = wvalid && !wready; prev_wdata = wdata;
            if (!awvalid && wvalid) n_aw_first++;
            if (awvalid && !wvalid) n_w_first++;
        end
    end

    function automatic logic [31:0] exp_addr(input int k);
        if (k < NUM_SRC) return BASE + 32'(4 * (k + 1));
        if (k == NUM_SRC) return BASE + 32'h2000;
        return BASE + 32'h20_0000;
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        logic [31:0] m;
        m = '0;
        if (k < NUM_SRC) return 32'd1;
        if (k == NUM_SRC) begin
            for (int s = 1; s <= NUM_SRC; s++) m[s] = 1'b1;
            return m;
        end
        return 32'd0;
    endfunction

    function automatic int log_errs(input int base);
        int e;
        e = 0;
        if (aw_log.size() != base + NW || w_log.size() != base + NW) return NW + 1;
        for (int k = 0; k < NW; k++)
            if (aw_log[base + k] !== exp_addr(k) || w_log[base + k] !== exp_data(k)) e++;
        return e;
    endfunction

    task automatic start_seq();
        start_i = 1'b1;
        @(posedge aclk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        ok = 1'b0; cyc = 0;
        while (cyc < limit && !ok) begin
            @(posedge aclk); #1;
            cyc++;
            ok = done_o;
        end
    endtask

    task automatic test_reset();
        #3 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        tests_run++;
        if ({busy_o, done_o, error_o, awvalid, wvalid, bready, awaddr, wdata, awprot} !== '0) begin
            fails++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b awv=%b wv=%b br=%b awaddr=%h wdata=%h, want all 0",
                busy_o, done_o, error_o, awvalid, wvalid, bready, awaddr, wdata);
        end
        tests_run++;
        if (wstrb !== 4'hF) begin fails++; $display("FAIL wstrb: got %h want f", wstrb); end
        @(negedge aclk) aresetn = 1'b1;
    endtask

    task automatic test_ready_slave();
        int base, bb, cyc; bit ok;
        base = aw_log.size(); bb = b_tot;
        start_seq();
        tests_run++;
        if (busy_o !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b want 1", busy_o); end
        wait_done(100, cyc, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL ready_done: done_o never rose in 100 cycles"); end
        tests_run++;
        if (cyc + 1 !== 2 * NW + 1) begin fails++; $display("FAIL ready_latency: got %0d want %0d", cyc + 1, 2 * NW + 1); end
        tests_run++;
        if (error_o !== 1'b0) begin fails++; $display("FAIL ready_error: got %b want 0", error_o); end
        tests_run++;
        if (log_errs(base) !== 0) begin fails++; $display("FAIL ready_writes: got %0d bad writes want 0", log_errs(base)); end
        tests_run++;
        if (b_tot - bb !== NW) begin fails++; $display("FAIL ready_bcount: got %0d want %0d", b_tot - bb, NW); end
    endtask

    task automatic test_channel_order();
        int base, bb, af, wf, cyc; bit ok;
        for (int o = 0; o < 2; o++) begin
            aw_delay = o ? 3 : 0; w_delay = o ? 0 : 3;
            base = aw_log.size(); bb = b_tot; af = n_aw_first; wf = n_w_first;
            start_seq();
            wait_done(200, cyc, ok);
            tests_run++;
            if (!ok) begin fails++; $display("FAIL order%0d_done: done_o never rose", o); end
            tests_run++;
            if (log_errs(base) !== 0) begin fails++; $display("FAIL order%0d_writes: got %0d bad/extra want 0", o, log_errs(base)); end
            tests_run++;
            if (b_tot - bb !== NW) begin fails++; $display("FAIL order%0d_bcount: got %0d want %0d", o, b_tot - bb, NW); end
            tests_run++;
            if (((o ? n_w_first - wf : n_aw_first - af) > 0) !== 1'b1) begin
                fails++; $display("FAIL order%0d_independent: got no single-channel-valid cycles want some", o);
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_bresp_error();
        int base, bb, cyc; bit ok;
        base = aw_log.size(); bb = b_tot;
        err_idx = b_tot + 1;
        start_seq();
        wait_done(100, cyc, ok);
        tests_run++;
        if (!(ok && error_o === 1'b1)) begin fails++; $display("FAIL bresp_err: got done=%b err=%b want 1 1", done_o, error_o); end
        tests_run++;
        if (log_errs(base) !== 0 || b_tot - bb !== NW) begin
            fails++; $display("FAIL bresp_all_writes: got %0d bad, %0d B want 0, %0d", log_errs(base), b_tot - bb, NW);
        end
        err_idx = -1;
        start_seq();
        tests_run++;
        if (error_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL bresp_clear: got err=%b done=%b want 0 0", error_o, done_o); end
        wait_done(100, cyc, ok);
        tests_run++;
        if (!(ok && error_o === 1'b0)) begin fails++; $display("FAIL bresp_clean_rerun: got done=%b err=%b want 1 0", done_o, error_o); end
    endtask

    task automatic test_timeout();
        int base, cyc; bit ok;
        aw_delay = 1100;
        base = aw_log.size();
        start_seq();
        repeat (998) @(posedge aclk);
        #1;
        tests_run++;
        if (error_o !== 1'b0) begin fails++; $display("FAIL timeout_early: got err=%b want 0 at cycle 999", error_o); end
        repeat (30) @(posedge aclk);
        #1;
        tests_run++;
        if (error_o !== 1'b1 || awvalid !== 1'b1) begin
            fails++; $display("FAIL timeout_flag: got err=%b awvalid=%b want 1 1", error_o, awvalid);
        end
        wait_done(6000, cyc, ok);
        tests_run++;
        if (!(ok && error_o === 1'b1 && log_errs(base) === 0)) begin
            fails++; $display("FAIL timeout_complete: got done=%b err=%b bad=%0d want 1 1 0", done_o, error_o, log_errs(base));
        end
        aw_delay = 0;
    endtask

    task automatic test_async_reset();
        int base, bb, n, cyc; bit ok;
        bb = b_tot;
        start_seq();
        n = 0;
        while (b_tot < bb + 1 && n < 50) begin @(posedge aclk); #2; n++; end
        b_stall = 1'b1;
        while (bready !== 1'b1 && n < 100) begin @(posedge aclk); #2; n++; end
        tests_run++;
        if (n >= 100) begin fails++; $display("FAIL arst_reach_resp: got timeout want RESP of write 2"); end
        #1 aresetn = 1'b0;
        #1;
        tests_run++;
        if ({busy_o, done_o, error_o, awvalid, wvalid, bready, awaddr, wdata} !== '0) begin
            fails++; $display("FAIL arst_outputs: got busy=%b br=%b awaddr=%h wdata=%h want all 0", busy_o, bready, awaddr, wdata);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1; b_stall = 1'b0;
        base = aw_log.size(); bb = b_tot;
        start_seq();
        tests_run++;
        if (busy_o !== 1'b1) begin fails++; $display("FAIL arst_release_start: got busy=%b want 1", busy_o); end
        wait_done(100, cyc, ok);
        tests_run++;
        if (!ok || log_errs(base) !== 0 || b_tot - bb !== NW) begin
            fails++; $display("FAIL arst_replay: got done=%b bad=%0d B=%0d want 1 0 %0d", done_o, log_errs(base), b_tot - bb, NW);
        end
    endtask

    task automatic test_busy_start();
        int base, bb, n;
        aw_delay = 1; w_delay = 2; b_delay = 1;
        base = aw_log.size(); bb = b_tot;
        start_seq();
        n = 0;
        while (n < 200) begin
            @(posedge aclk); #1;
            n++;
            if (done_o) break;
            start_i = 1'($urandom_range(0, 1));
        end
        start_i = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        tests_run++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL busy_start_state: got done=%b busy=%b want 1 0", done_o, busy_o); end
        tests_run++;
        if (b_tot - bb !== NW || log_errs(base) !== 0) begin
            fails++; $display("FAIL busy_start_bcount: got %0d B, %0d bad want %0d, 0", b_tot - bb, log_errs(base), NW);
        end
        aw_delay = 0; w_delay = 0; b_delay = 0;
    endtask

    task automatic test_random();
        int base, bb, e, cyc; bit ok, exp_err;
        for (int it = 0; it < 6; it++) begin
            aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4); b_delay = $urandom_range(0, 4);
            e = $urandom_range(0, NW);
            base = aw_log.size(); bb = b_tot;
            err_idx = (e < NW) ? b_tot + e : -1;
            exp_err = e < NW;
            start_seq();
            wait_done(300, cyc, ok);
            tests_run++;
            if (!ok || error_o !== exp_err) begin fails++; $display("FAIL rand%0d_status: got done=%b err=%b want 1 %b", it, done_o, error_o, exp_err); end
            tests_run++;
            if (log_errs(base) !== 0 || b_tot - bb !== NW) begin
                fails++; $display("FAIL rand%0d_writes: got %0d bad, %0d B want 0, %0d", it, log_errs(base), b_tot - bb, NW);
            end
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; err_idx = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ready_slave();
        test_channel_order();
        test_bresp_error();
        test_timeout();
        test_async_reset();
        test_busy_start();
        test_random();
        tests_run++;
        if (viol !== 0) begin fails++; $display("FAIL axi_stability: got %0d valid/payload violations want 0", viol); end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
